// File: rtl/alu_issue.sv
// RV32I OP / OP-IMM / BRANCH issue stage. It decodes one instruction, drives the
// external combinational ALU from a private register file, then retires the result.
module alu_issue #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    output logic [3:0]  alu_command,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    input  logic [31:0] alu_res,
    output logic        done,
    output logic [31:0] done_result,
    output logic        branch_taken,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_XOR = 4'd4;
    localparam logic [3:0] CMD_SLL = 4'd5;
    localparam logic [3:0] CMD_SRL = 4'd6;
    localparam logic [3:0] CMD_SRA = 4'd7;
    localparam logic [3:0] CMD_EQ  = 4'd8;
    localparam logic [3:0] CMD_NE  = 4'd9;
    localparam logic [3:0] CMD_LT  = 4'd10;
    localparam logic [3:0] CMD_LTU = 4'd11;
    localparam logic [3:0] CMD_GE  = 4'd12;
    localparam logic [3:0] CMD_GEU = 4'd13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [5:0] REG_LIMIT  = 6'(NUM_REGS);

    function automatic logic reg_idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < REG_LIMIT);
    endfunction

    function automatic logic [3:0] arith_cmd(input logic [2:0] f3, input logic alt);
        logic [3:0] cmd;
        case (f3)
            3'b000:  cmd = alt ? CMD_SUB : CMD_ADD;
            3'b001:  cmd = CMD_SLL;
            3'b010:  cmd = CMD_LT;
            3'b011:  cmd = CMD_LTU;
            3'b100:  cmd = CMD_XOR;
            3'b101:  cmd = alt ? CMD_SRA : CMD_SRL;
            3'b110:  cmd = CMD_OR;
            3'b111:  cmd = CMD_AND;
            default: cmd = CMD_ADD;
        endcase
        return cmd;
    endfunction

    function automatic logic is_shift(input logic [3:0] cmd);
        return (cmd == CMD_SLL) || (cmd == CMD_SRL) || (cmd == CMD_SRA);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] regs_r [32];

    logic        ready_r;
    logic [3:0]  cmd_r;
    logic [31:0] lhs_r;
    logic [31:0] rhs_r;
    logic [4:0]  rd_r;
    logic        write_r;
    logic        branch_r;
    logic        bad_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        taken_r;
    logic        illegal_r;

    logic        accept_s;
    logic        capture_s;
    logic        retire_s;
    logic        ready_next_s;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] dbg_val_s;

    logic [3:0]  dec_cmd_s;
    logic [31:0] rhs_sel_s;
    logic        dec_write_s;
    logic        dec_branch_s;
    logic        dec_bad_s;
    logic        br_f3_ok_s;
    logic [3:0]  fin_cmd_s;
    logic [31:0] fin_lhs_s;
    logic [31:0] fin_rhs_s;

    assign opcode_s = instr_word[6:0];
    assign rd_s     = instr_word[11:7];
    assign funct3_s = instr_word[14:12];
    assign rs1_s    = instr_word[19:15];
    assign rs2_s    = instr_word[24:20];
    assign funct7_s = instr_word[31:25];
    assign imm_s    = {{20{instr_word[31]}}, instr_word[31:20]};

    // Register file read ports; x0 and unimplemented indices read as zero.
    always_comb begin
        if ((rs1_s != 5'd0) && reg_idx_ok(rs1_s)) begin
            rs1_val_s = regs_r[rs1_s];
        end else begin
            rs1_val_s = 32'd0;
        end
        if ((rs2_s != 5'd0) && reg_idx_ok(rs2_s)) begin
            rs2_val_s = regs_r[rs2_s];
        end else begin
            rs2_val_s = 32'd0;
        end
        if ((dbg_addr != 5'd0) && reg_idx_ok(dbg_addr)) begin
            dbg_val_s = regs_r[dbg_addr];
        end else begin
            dbg_val_s = 32'd0;
        end
    end

    // Instruction decode: ALU command, right-operand source and legality.
    always_comb begin
        dec_cmd_s    = CMD_ADD;
        rhs_sel_s    = rs2_val_s;
        dec_write_s  = 1'b0;
        dec_branch_s = 1'b0;
        dec_bad_s    = 1'b0;
        br_f3_ok_s   = 1'b1;
        case (opcode_s)
            OPC_OP: begin
                dec_write_s = 1'b1;
                dec_cmd_s   = arith_cmd(funct3_s, funct7_s[5]);
                dec_bad_s   = !((funct7_s == F7_ZERO) ||
                                ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) ||
                              !reg_idx_ok(rs1_s) || !reg_idx_ok(rs2_s) || !reg_idx_ok(rd_s);
            end
            OPC_IMM: begin
                dec_write_s = 1'b1;
                rhs_sel_s   = imm_s;
                dec_cmd_s   = arith_cmd(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
                dec_bad_s   = ((funct3_s == 3'b001) && (funct7_s != F7_ZERO)) ||
                              ((funct3_s == 3'b101) && (funct7_s != F7_ZERO) && (funct7_s != F7_ALT)) ||
                              !reg_idx_ok(rs1_s) || !reg_idx_ok(rd_s);
            end
            OPC_BRANCH: begin
                dec_branch_s = 1'b1;
                case (funct3_s)
                    3'b000:  dec_cmd_s = CMD_EQ;
                    3'b001:  dec_cmd_s = CMD_NE;
                    3'b100:  dec_cmd_s = CMD_LT;
                    3'b101:  dec_cmd_s = CMD_GE;
                    3'b110:  dec_cmd_s = CMD_LTU;
                    3'b111:  dec_cmd_s = CMD_GEU;
                    default: br_f3_ok_s = 1'b0;
                endcase
                dec_bad_s = !br_f3_ok_s || !reg_idx_ok(rs1_s) || !reg_idx_ok(rs2_s);
            end
            default: dec_bad_s = 1'b1;
        endcase
    end

    // Final operands: the ALU shifts by the full rhs, so shift amounts are masked here.
    always_comb begin
        if (dec_bad_s) begin
            fin_cmd_s = CMD_ADD;
            fin_lhs_s = 32'd0;
            fin_rhs_s = 32'd0;
        end else begin
            fin_cmd_s = dec_cmd_s;
            fin_lhs_s = rs1_val_s;
            fin_rhs_s = is_shift(dec_cmd_s) ? {27'd0, rhs_sel_s[4:0]} : rhs_sel_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        case (state_r)
            ST_IDLE: state_next_s = (instr_valid && ready_r) ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_next_s = ST_WB;
            ST_WB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: per-state strobes for the datapath.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && instr_valid && ready_r;
        capture_s    = (state_r == ST_EXEC);
        retire_s     = (state_r == ST_WB);
        ready_next_s = (state_next_s == ST_IDLE);
    end

    // Issue, capture and retire registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r   <= 1'b0;
            cmd_r     <= CMD_ADD;
            lhs_r     <= 32'd0;
            rhs_r     <= 32'd0;
            rd_r      <= 5'd0;
            write_r   <= 1'b0;
            branch_r  <= 1'b0;
            bad_r     <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
            taken_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            if (accept_s) begin
                cmd_r    <= fin_cmd_s;
                lhs_r    <= fin_lhs_s;
                rhs_r    <= fin_rhs_s;
                rd_r     <= rd_s;
                write_r  <= dec_write_s && !dec_bad_s && (rd_s != 5'd0);
                branch_r <= dec_branch_s && !dec_bad_s;
                bad_r    <= dec_bad_s;
            end
            if (capture_s) begin
                done_r    <= 1'b1;
                result_r  <= bad_r ? 32'd0 : alu_res;
                taken_r   <= branch_r && alu_res[0];
                illegal_r <= bad_r;
            end else if (retire_s) begin
                done_r    <= 1'b0;
                result_r  <= 32'd0;
                taken_r   <= 1'b0;
                illegal_r <= 1'b0;
            end
        end
    end

    // Register file write at the end of WB; x0 and unimplemented entries never load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (retire_s && write_r && (rd_r == 5'(i)) && (i < NUM_REGS)) begin
                    regs_r[i] <= result_r;
                end
            end
        end
    end

    assign instr_ready  = ready_r;
    assign alu_command  = cmd_r;
    assign alu_lhs      = lhs_r;
    assign alu_rhs      = rhs_r;
    assign done         = done_r;
    assign done_result  = result_r;
    assign branch_taken = taken_r;
    assign illegal      = illegal_r;
    assign dbg_data     = dbg_val_s;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a 32-register and a 16-register instance share stimulus and
// are checked against an instruction-level reference model and an ALU model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [4:0]  dbg_addr;

    logic        rdy   [2];
    logic [3:0]  cmd   [2];
    logic [31:0] lhs   [2];
    logic [31:0] rhs   [2];
    logic [31:0] ares  [2];
    logic        dn    [2];
    logic [31:0] dres  [2];
    logic        tkn   [2];
    logic        ill   [2];
    logic [31:0] dbg   [2];

    logic [31:0] ref_rf [2][32];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_acc = 0;
    int          prev_acc = 0;
    logic [31:0] last_res;
    logic        last_tk;
    logic        last_ill32;
    logic        last_ill16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b;
            4'd6:    r = a >> b;
            4'd7:    r = $unsigned($signed(a) >>> b);
            4'd8:    r = {31'd0, a == b};
            4'd9:    r = {31'd0, a != b};
            4'd10:   r = {31'd0, $signed(a) < $signed(b)};
            4'd11:   r = {31'd0, a < b};
            4'd12:   r = {31'd0, $signed(a) >= $signed(b)};
            4'd13:   r = {31'd0, a >= b};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign ares[0] = alu_model(cmd[0], lhs[0], rhs[0]);
    assign ares[1] = alu_model(cmd[1], lhs[1], rhs[1]);

    alu_issue #(.NUM_REGS(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy[0]),
        .instr_word(instr_word), .alu_command(cmd[0]), .alu_lhs(lhs[0]), .alu_rhs(rhs[0]),
        .alu_res(ares[0]), .done(dn[0]), .done_result(dres[0]), .branch_taken(tkn[0]),
        .illegal(ill[0]), .dbg_addr(dbg_addr), .dbg_data(dbg[0])
    );

    alu_issue #(.NUM_REGS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy[1]),
        .instr_word(instr_word), .alu_command(cmd[1]), .alu_lhs(lhs[1]), .alu_rhs(rhs[1]),
        .alu_res(ares[1]), .done(dn[1]), .done_result(dres[1]), .branch_taken(tkn[1]),
        .illegal(ill[1]), .dbg_addr(dbg_addr), .dbg_data(dbg[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input string base, input int k);
        return $sformatf("%s_n%0d", base, (k == 0) ? 32 : 16);
    endfunction

    // Instruction-level reference: result, legality, write-back and branch outcome.
    function automatic void ref_exec(input int k, input logic [31:0] w,
                                     output bit e_ill, output logic [31:0] res,
                                     output bit wr, output bit tk);
        int nr;
        bit isop;
        logic [4:0] d, s1, s2, sh;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] a, b;
        nr = (k == 0) ? 32 : 16;
        d = w[11:7]; f3 = w[14:12]; s1 = w[19:15]; s2 = w[24:20]; f7 = w[31:25];
        a = ref_rf[k][s1];
        b = ref_rf[k][s2];
        isop = (w[6:0] == 7'h33);
        e_ill = 1'b0; res = 32'd0; wr = 1'b0; tk = 1'b0;
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            if (!isop) b = {{20{w[31]}}, w[31:20]};
            sh = b[4:0];
            e_ill = (int'(s1) >= nr) || (int'(d) >= nr) || (isop && int'(s2) >= nr);
            case (f3)
                3'd0: if (!isop || f7 == 7'h00) res = a + b;
                      else if (f7 == 7'h20) res = a - b;
                      else e_ill = 1'b1;
                3'd1: if (f7 == 7'h00) res = a << sh; else e_ill = 1'b1;
                3'd5: if (f7 == 7'h00) res = a >> sh;
                      else if (f7 == 7'h20) res = $unsigned($signed(a) >>> sh);
                      else e_ill = 1'b1;
                default: begin
                    if (isop && f7 != 7'h00) e_ill = 1'b1;
                    case (f3)
                        3'd2:    res = {31'd0, $signed(a) < $signed(b)};
                        3'd3:    res = {31'd0, a < b};
                        3'd4:    res = a ^ b;
                        3'd6:    res = a | b;
                        default: res = a & b;
                    endcase
                end
            endcase
            wr = !e_ill && (d != 5'd0);
        end else if (w[6:0] == 7'h63) begin
            e_ill = (int'(s1) >= nr) || (int'(s2) >= nr);
            case (f3)
                3'd0:    res = {31'd0, a == b};
                3'd1:    res = {31'd0, a != b};
                3'd4:    res = {31'd0, $signed(a) < $signed(b)};
                3'd5:    res = {31'd0, $signed(a) >= $signed(b)};
                3'd6:    res = {31'd0, a < b};
                3'd7:    res = {31'd0, a >= b};
                default: e_ill = 1'b1;
            endcase
            tk = !e_ill && res[0];
        end else begin
            e_ill = 1'b1;
        end
        if (e_ill) res = 32'd0;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, r1, f3, d, 7'h13};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
        return {7'd0, r2, r1, f3, 5'd0, 7'h63};
    endfunction

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [6:0] rand_f7();
        int r;
        r = $urandom_range(0, 5);
        return (r < 3) ? 7'h00 : (r < 5) ? 7'h20 : 7'($urandom);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] d, r1, r2;
        logic [2:0] f3;
        logic [11:0] imm;
        int sel;
        d = rand_reg(); r1 = rand_reg();
        r2 = ($urandom_range(0, 3) == 0) ? r1 : rand_reg();
        f3 = 3'($urandom_range(0, 7));
        sel = $urandom_range(0, 9);
        if (sel < 4) return enc_r(rand_f7(), r2, r1, f3, d);
        if (sel < 8) begin
            imm = 12'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = rand_f7();
            return enc_i(imm, r1, f3, d);
        end
        if (sel < 9) return enc_b(f3, r1, r2);
        return $urandom;
    endfunction

    task automatic issue(input logic [31:0] w, input bit hold, input bit chk_rhs, input logic [31:0] exp_rhs);
        bit e_ill [2];
        logic [31:0] e_res [2];
        bit e_wr [2];
        bit e_tk [2];
        int n;
        for (int k = 0; k < 2; k++) ref_exec(k, w, e_ill[k], e_res[k], e_wr[k], e_tk[k]);
        instr_word  = w;
        instr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 2; k++) check_eq(tg("ready_idle", k), 32'(rdy[k]), 32'd1);
        @(posedge clk);
        #1;
        prev_acc = last_acc;
        last_acc = cyc;
        if (!hold) instr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq(tg("ready_exec", k), 32'(rdy[k]), 32'd0);
            check_eq(tg("done_exec", k), 32'(dn[k]), 32'd0);
            if (e_ill[k]) begin
                check_eq(tg("ill_cmd", k), 32'(cmd[k]), 32'd0);
                check_eq(tg("ill_lhs", k), lhs[k], 32'd0);
                check_eq(tg("ill_rhs", k), rhs[k], 32'd0);
            end
        end
        if (chk_rhs) check_eq("alu_rhs_n32", rhs[0], exp_rhs);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq(tg("done_wb", k), 32'(dn[k]), 32'd1);
            check_eq(tg("done_result", k), dres[k], e_res[k]);
            check_eq(tg("branch_taken", k), 32'(tkn[k]), 32'(e_tk[k]));
            check_eq(tg("illegal", k), 32'(ill[k]), 32'(e_ill[k]));
            if (e_wr[k]) ref_rf[k][w[11:7]] = e_res[k];
        end
        last_res   = dres[0];
        last_tk    = tkn[0];
        last_ill32 = ill[0];
        last_ill16 = ill[1];
    endtask

    task automatic check_rf();
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            for (int k = 0; k < 2; k++) check_eq(tg($sformatf("dbg_x%0d", a), k), dbg[k], ref_rf[k][a]);
        end
    endtask

    task automatic clear_ref();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) ref_rf[k][a] = 32'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; instr_valid = 1'b1; instr_word = 32'hFFB00093; dbg_addr = 5'd0;
        clear_ref();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq(tg("rst_ready", k), 32'(rdy[k]), 32'd0);
            check_eq(tg("rst_done", k), 32'(dn[k]), 32'd0);
            check_eq(tg("rst_cmd", k), 32'(cmd[k]), 32'd0);
            check_eq(tg("rst_lhs", k), lhs[k], 32'd0);
        end
        instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_eq(tg("post_rst_ready", k), 32'(rdy[k]), 32'd1);
        check_rf();

        issue(32'hFFB00093, 1'b0, 1'b0, 32'd0);
        check_eq("addi_neg5", last_res, 32'hFFFFFFFB);
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b0, 1'b0, 32'd0);
        check_eq("add_x1x1", last_res, 32'hFFFFFFF6);
        check_rf();

        issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1), 1'b0, 1'b0, 32'd0);
        issue(enc_i(12'd31, 5'd1, 3'd1, 5'd1), 1'b0, 1'b0, 32'd0);
        check_eq("slli_31", last_res, 32'h80000000);
        issue(enc_i(12'd33, 5'd0, 3'd0, 5'd4), 1'b0, 1'b0, 32'd0);
        issue(enc_r(7'h20, 5'd4, 5'd1, 3'd5, 5'd3), 1'b0, 1'b1, 32'd1);
        check_eq("sra_by33", last_res, 32'hC0000000);
        issue(enc_i(12'h41F, 5'd1, 3'd5, 5'd5), 1'b0, 1'b0, 32'd0);
        check_eq("srai_31", last_res, 32'hFFFFFFFF);
        issue(enc_i(12'd31, 5'd1, 3'd5, 5'd6), 1'b0, 1'b0, 32'd0);
        check_eq("srli_31", last_res, 32'h00000001);

        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd7), 1'b0, 1'b0, 32'd0);
        issue(enc_b(3'd4, 5'd7, 5'd0), 1'b0, 1'b0, 32'd0);
        check_eq("blt_taken", 32'(last_tk), 32'd1);
        check_eq("blt_result", last_res, 32'd1);
        issue(enc_b(3'd6, 5'd7, 5'd0), 1'b0, 1'b0, 32'd0);
        check_eq("bltu_not_taken", 32'(last_tk), 32'd0);

        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1'b0, 1'b0, 32'd0);
        check_eq("addi_x0_res", last_res, 32'd7);
        issue(enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd20), 1'b0, 1'b0, 32'd0);
        check_eq("x20_legal_n32", 32'(last_ill32), 32'd0);
        check_eq("x20_illegal_n16", 32'(last_ill16), 32'd1);
        issue(32'h12345037, 1'b0, 1'b0, 32'd0);
        check_eq("lui_illegal", 32'(last_ill32), 32'd1);
        check_rf();

        for (int i = 0; i < 300; i++) begin
            issue(rand_instr(), 1'b0, 1'b0, 32'd0);
            if (i % 75 == 74) check_rf();
        end

        for (int i = 0; i < 3; i++) begin
            issue(rand_instr(), 1'b1, 1'b0, 32'd0);
            if (i > 0) check_eq("accept_interval", 32'(last_acc - prev_acc), 32'd3);
        end
        instr_valid = 1'b0;
        check_rf();

        instr_word = enc_i(12'd55, 5'd0, 3'd0, 5'd9);
        instr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        clear_ref();
        #1;
        for (int k = 0; k < 2; k++) check_eq(tg("abort_done", k), 32'(dn[k]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_eq(tg("abort_no_done", k), 32'(dn[k]), 32'd0);
        end
        check_rf();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
